echo_indication_serializer: RTL and testbench

Downstream stage for the Echo block's `indication$heard` output. It buffers completed `heard(meth, v)` indications in a small FIFO and serializes each one into a stream of 32-bit words on an ENA/RDY enqueue port that feeds the host response pipe. It decouples Echo's single-cycle `heard` firing from a host pipe that may stall. It also keeps a running count of messages emitted.

---
 rtl/echo_indication_serializer_if.sv | 20 ++
 rtl/echo_indication_serializer.sv | 104 ++++++++++
 tb/tb_echo_indication_serializer.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/echo_indication_serializer_if.sv
// Echo heard-indication input, host enqueue pipe and sent-count status, grouped as one bundle.
interface echo_indication_serializer_if;
  logic        heard__ENA;
  logic [31:0] heard_meth;
  logic [31:0] heard_v;
  logic        heard__RDY;
  logic        pipe_enq__ENA;
  logic [31:0] pipe_enq_v;
  logic        pipe_enq__RDY;
  logic [31:0] status_sent;

  modport master (
    output heard__ENA, heard_meth, heard_v, pipe_enq__RDY,
    input  heard__RDY, pipe_enq__ENA, pipe_enq_v, status_sent
  );
  modport slave (
    input  heard__ENA, heard_meth, heard_v, pipe_enq__RDY,
    output heard__RDY, pipe_enq__ENA, pipe_enq_v, status_sent
  );
endinterface

// File: rtl/echo_indication_serializer.sv
// Buffers heard(meth, v) indications and serializes each into header/payload words on the host pipe.
// Optional ECHO_SER_CHECKSUM_EN appends a third word (header ^ v) to every message.
module echo_indication_serializer #(
  parameter int DEPTH = 2
) (
  input logic CLK,
  input logic nRST,
  echo_indication_serializer_if.slave bus
);
  localparam int AW = (DEPTH > 2) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);
`ifdef ECHO_SER_CHECKSUM_EN
  localparam logic [15:0] LEN = 16'd3;
`else
  localparam logic [15:0] LEN = 16'd2;
`endif

  typedef enum logic [1:0] {S_IDLE, S_HDR, S_PAY, S_CSUM} state_t;

  state_t        state, state_n;
  logic [15:0]   meth_q [DEPTH];
  logic [31:0]   v_q    [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic [31:0]   sent;
  logic          push, pop, ena, more;
  logic [31:0]   hdr, word;
  logic          unused_meth_hi;

  assign unused_meth_hi   = ^bus.heard_meth[31:16];
  assign bus.heard__RDY   = (count != CNT_FULL);
  assign push             = bus.heard__ENA & bus.heard__RDY;
  assign hdr              = {meth_q[rd_ptr], LEN};
  // Continue straight into the next header only if something remains after this pop.
  assign more             = (count > (AW+1)'(1));
  assign bus.pipe_enq__ENA = ena;
  assign bus.pipe_enq_v    = word;
  assign bus.status_sent   = sent;

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state  <= S_IDLE;
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      sent   <= '0;
    end else begin
      state <= state_n;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        sent   <= sent + 32'd1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (nRST && push) begin
      meth_q[wr_ptr] <= bus.heard_meth[15:0];
      v_q[wr_ptr]    <= bus.heard_v;
    end
  end

  always_comb begin
    state_n = state;
    ena     = 1'b0;
    word    = '0;
    pop     = 1'b0;
    case (state)
      S_IDLE: if (count != '0) state_n = S_HDR;
      S_HDR: begin
        ena  = 1'b1;
        word = hdr;
        if (bus.pipe_enq__RDY) state_n = S_PAY;
      end
      S_PAY: begin
        ena  = 1'b1;
        word = v_q[rd_ptr];
        if (bus.pipe_enq__RDY) begin
`ifdef ECHO_SER_CHECKSUM_EN
          state_n = S_CSUM;
`else
          pop     = 1'b1;
          state_n = more ? S_HDR : S_IDLE;
`endif
        end
      end
      S_CSUM: begin
        ena  = 1'b1;
        word = hdr ^ v_q[rd_ptr];
        if (bus.pipe_enq__RDY) begin
          pop     = 1'b1;
          state_n = more ? S_HDR : S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end
endmodule

// File: tb/tb_echo_indication_serializer.sv
// Scoreboard bench: expected words queued at push time, compared as the host pipe accepts them.
module tb_echo_indication_serializer;
  localparam int DEPTH = 2;
`ifdef ECHO_SER_CHECKSUM_EN
  localparam logic [15:0] LEN = 16'd3;
`else
  localparam logic [15:0] LEN = 16'd2;
`endif

  logic CLK, nRST;
  echo_indication_serializer_if bus ();

  echo_indication_serializer #(.DEPTH(DEPTH)) dut (
    .CLK (CLK),
    .nRST(nRST),
    .bus (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] sbq [$];
  int          wi = 0;
  int          exp_sent = 0;
  logic        hold_pend = 1'b0;
  logic [31:0] hold_word = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] mk_hdr(input logic [31:0] m);
    return {m[15:0], LEN};
  endfunction

  function automatic logic [31:0] last_word(input logic [31:0] m, input logic [31:0] v);
`ifdef ECHO_SER_CHECKSUM_EN
    return mk_hdr(m) ^ v;
`else
    return v;
`endif
  endfunction

  // Scoreboard consumer: sampled on the falling edge, values are those the next rising edge uses.
  always @(negedge CLK) begin
    if (!nRST) begin
      sbq.delete();
      wi        = 0;
      exp_sent  = 0;
      hold_pend = 1'b0;
    end else begin
      chk("sent", bus.status_sent, 32'(exp_sent));
      if (hold_pend) begin
        chk("hold_ena", {31'b0, bus.pipe_enq__ENA}, 32'd1);
        chk("hold_word", bus.pipe_enq_v, hold_word);
      end
      hold_pend = bus.pipe_enq__ENA && !bus.pipe_enq__RDY;
      hold_word = bus.pipe_enq_v;
      if (bus.pipe_enq__ENA && bus.pipe_enq__RDY) begin
        if (sbq.size() == 0) chk("sb_unexpected", 32'(sbq.size()), 32'd1);
        else begin
          chk("word", bus.pipe_enq_v, sbq.pop_front());
          if (wi == int'(LEN) - 1) begin
            wi = 0;
            exp_sent++;
          end else wi++;
        end
      end
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic push_msg(input logic [31:0] m, input logic [31:0] v, input logic acc);
    bus.heard__ENA = 1'b1;
    bus.heard_meth = m;
    bus.heard_v    = v;
    chk("push_rdy", {31'b0, bus.heard__RDY}, {31'b0, acc});
    if (acc) begin
      sbq.push_back(mk_hdr(m));
      sbq.push_back(v);
`ifdef ECHO_SER_CHECKSUM_EN
      sbq.push_back(mk_hdr(m) ^ v);
`endif
    end
    step();
    bus.heard__ENA = 1'b0;
  endtask

  task automatic wait_word(input string tag, input logic [31:0] w);
    logic found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      @(negedge CLK);
      if (bus.pipe_enq__ENA && bus.pipe_enq_v == w) found = 1'b1;
    end
    chk(tag, {31'b0, found}, 32'd1);
  endtask

  task automatic drain(input string tag);
    logic done = 1'b0;
    for (int i = 0; i < 60 && !done; i++) begin
      @(negedge CLK);
      if (sbq.size() == 0 && !bus.pipe_enq__ENA) done = 1'b1;
    end
    chk(tag, 32'(sbq.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    nRST = 1'b0;
    bus.heard__ENA = 1'b0;
    bus.heard_meth = '0;
    bus.heard_v = '0;
    bus.pipe_enq__RDY = 1'b0;

    // Reset, with an indication firing that must be ignored.
    step();
    bus.heard__ENA = 1'b1;
    bus.heard_meth = 32'hFFFF_00AA;
    bus.heard_v = 32'h0BAD_0BAD;
    step();
    step();
    @(negedge CLK);
    chk("rst_ena", {31'b0, bus.pipe_enq__ENA}, 32'd0);
    chk("rst_word", bus.pipe_enq_v, 32'd0);
    chk("rst_rdy", {31'b0, bus.heard__RDY}, 32'd1);
    step();
    bus.heard__ENA = 1'b0;
    nRST = 1'b1;
    bus.pipe_enq__RDY = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      chk("idle_ena", {31'b0, bus.pipe_enq__ENA}, 32'd0);
      chk("idle_rdy", {31'b0, bus.heard__RDY}, 32'd1);
      step();
    end

    // Single message with latency check; upper meth bits must be dropped.
    push_msg(32'hABCD_0012, 32'hDEAD_BEEF, 1'b1);
    @(negedge CLK);
    chk("lat_idle", {31'b0, bus.pipe_enq__ENA}, 32'd0);
    step();
    @(negedge CLK);
    chk("lat_hdr_ena", {31'b0, bus.pipe_enq__ENA}, 32'd1);
`ifdef ECHO_SER_CHECKSUM_EN
    chk("lat_hdr", bus.pipe_enq_v, 32'h0012_0003);
`else
    chk("lat_hdr", bus.pipe_enq_v, 32'h0012_0002);
`endif
    step();
    @(negedge CLK);
    chk("lat_pay", bus.pipe_enq_v, 32'hDEAD_BEEF);
`ifdef ECHO_SER_CHECKSUM_EN
    step();
    @(negedge CLK);
    chk("lat_csum", bus.pipe_enq_v, 32'h0012_0003 ^ 32'hDEAD_BEEF);
`endif
    drain("single_drain");
    chk("single_sent", bus.status_sent, 32'd1);

    // Backpressure on the header for 4 cycles.
    bus.pipe_enq__RDY = 1'b0;
    push_msg(32'h34, 32'hCAFE_F00D, 1'b1);
    wait_word("bp_hdr_seen", mk_hdr(32'h34));
    for (int i = 0; i < 3; i++) begin
      step();
      @(negedge CLK);
      chk("bp_hdr_stable", bus.pipe_enq_v, mk_hdr(32'h34));
    end
    step();
    bus.pipe_enq__RDY = 1'b1;
    step();
    @(negedge CLK);
    chk("bp_pay", bus.pipe_enq_v, 32'hCAFE_F00D);
    drain("bp_drain");

    // Fill the FIFO under backpressure, extra push refused, then drain in order.
    bus.pipe_enq__RDY = 1'b0;
    for (int i = 0; i < DEPTH; i++) push_msg(32'h40 + 32'(i), 32'h1000_0000 + 32'(i), 1'b1);
    @(negedge CLK);
    chk("full_rdy", {31'b0, bus.heard__RDY}, 32'd0);
    push_msg(32'h4F, 32'hBBBB_BBBB, 1'b0);
    bus.pipe_enq__RDY = 1'b1;
    @(negedge CLK);
    chk("full_rdy_hold", {31'b0, bus.heard__RDY}, 32'd0);
    drain("fill_drain");
    chk("fill_sent", bus.status_sent, 32'(3 + DEPTH) - 32'd1);

    // Push in the same cycle as the pop of the only queued message.
    push_msg(32'h55, 32'h1111_1111, 1'b1);
    wait_word("ovl_last", last_word(32'h55, 32'h1111_1111));
    push_msg(32'h66, 32'h2222_2222, 1'b1);
    @(negedge CLK);
    chk("ovl_idle", {31'b0, bus.pipe_enq__ENA}, 32'd0);
    chk("ovl_rdy", {31'b0, bus.heard__RDY}, 32'd1);
    step();
    @(negedge CLK);
    chk("ovl_hdr", bus.pipe_enq_v, mk_hdr(32'h66));
    drain("ovl_drain");

    // Reset in the middle of a payload with two messages queued.
    bus.pipe_enq__RDY = 1'b0;
    push_msg(32'h77, 32'h7777_0000, 1'b1);
    push_msg(32'h78, 32'h7878_0000, 1'b1);
    wait_word("rst_hdr_seen", mk_hdr(32'h77));
    bus.pipe_enq__RDY = 1'b1;
    step();
    bus.pipe_enq__RDY = 1'b0;
    @(negedge CLK);
    chk("rst_mid_pay", bus.pipe_enq_v, 32'h7777_0000);
    step();
    nRST = 1'b0;
    step();
    step();
    nRST = 1'b1;
    bus.pipe_enq__RDY = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      chk("post_rst_ena", {31'b0, bus.pipe_enq__ENA}, 32'd0);
      chk("post_rst_rdy", {31'b0, bus.heard__RDY}, 32'd1);
      step();
    end
    chk("post_rst_sent", bus.status_sent, 32'd0);
    push_msg(32'h99, 32'h9999_9999, 1'b1);
    drain("post_rst_drain");
    chk("post_rst_sent1", bus.status_sent, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
